// File: rtl/movement_button_conditioner.sv
// movement_button_conditioner
//
// Front end for the four movement keys and the start-game switch.
// Each raw input goes through its own channel: a synchroniser chain, a
// debounce counter, and a debounced state flop. Each key then feeds a
// small RELEASED/HELD FSM. That FSM turns one debounced press into
// exactly one single-cycle pulse, so one physical press moves the
// selection light exactly one cell.
//
// Optional feature macro: AUTO_REPEAT_EN
//   When defined, a key that stays held produces repeat pulses. The first
//   repeat comes REPEAT_DELAY cycles after the initial pulse, and further
//   repeats follow every REPEAT_PERIOD cycles. When the macro is undefined,
//   no repeat hardware exists.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-low reset
//   rawKeys[3:0]    raw keys {up, down, right, left}; pressed level is set
//                   by RAW_ACTIVE_LOW
//   rawSwitch       raw start-game switch, active-high
//   leftButton      one-cycle press pulse
//   rightButton     one-cycle press pulse
//   upButton        one-cycle press pulse
//   downButton      one-cycle press pulse
//   startGameSwitch debounced switch level
//   anyKeyHeld      OR of the four debounced key states
//
// All outputs are registered.

module movement_button_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int RAW_ACTIVE_LOW  = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rawKeys,
   input  logic       rawSwitch,
   output logic       leftButton,
   output logic       rightButton,
   output logic       upButton,
   output logic       downButton,
   output logic       startGameSwitch,
   output logic       anyKeyHeld
);

   localparam int NUM_CH = 5;
   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // This is the idle (released) raw level of a key. The sync chains reset
   // to it, so coming out of reset does not look like a press.
   localparam logic KEY_IDLE = (RAW_ACTIVE_LOW != 0);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("movement_button_conditioner: illegal parameter value");
   end

   typedef enum logic {
      KEY_RELEASED = 1'b0,
      KEY_HELD     = 1'b1
   } key_state_t;

   logic [NUM_CH-1:0]      raw_in;
   logic [NUM_CH-1:0]      norm;
   logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
   logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
   logic [CNT_W-1:0]       cnt_q  [NUM_CH];
   logic [CNT_W-1:0]       cnt_d  [NUM_CH];
   logic [NUM_CH-1:0]      deb_q;
   logic [NUM_CH-1:0]      deb_d;
   key_state_t             state_q [4];
   key_state_t             state_d [4];
   logic [3:0]             pulse_q;
   logic [3:0]             pulse_d;
   logic                   any_held_q;
   logic                   any_held_d;

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
   localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);

   // rep_phase_q records that the first (REPEAT_DELAY) repeat has already
   // fired. After that, the spacing between pulses is REPEAT_PERIOD.
   logic [REP_W-1:0] rep_cnt_q [4];
   logic [REP_W-1:0] rep_cnt_d [4];
   logic [3:0]       rep_phase_q;
   logic [3:0]       rep_phase_d;
`endif

   assign raw_in = {rawSwitch, rawKeys};

   // Synchroniser shift, and normalisation of keys to pressed = 1.
   // The switch is already active-high, so it passes through unchanged.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
      end
      norm = '0;
      for (int i = 0; i < 4; i++) begin
         norm[i] = sync_q[i][SYNC_STAGES-1] ^ KEY_IDLE;
      end
      norm[4] = sync_q[4][SYNC_STAGES-1];
   end

   // Debounce. The counter runs only while the synchronised input disagrees
   // with the accepted state. Any agreement restarts the count from zero.
   // On the DEBOUNCE_CYCLES-th disagreement the state flips and the counter
   // is left at zero, so it can never wrap.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = '0;
         if (norm[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
      any_held_d = |deb_d[3:0];
   end

   // Per-key press FSM. This logic looks at deb_d rather than deb_q.
   // As a result, the pulse register loads on the same edge the debounced
   // state flips, and the pulse appears together with anyKeyHeld.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         pulse_d[k] = 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_cnt_d[k]   = '0;
         rep_phase_d[k] = 1'b0;
`endif
         case (state_q[k])
            KEY_RELEASED: begin
               if (deb_d[k]) begin
                  state_d[k] = KEY_HELD;
                  pulse_d[k] = 1'b1;
               end
            end
            KEY_HELD: begin
               if (!deb_d[k]) begin
                  state_d[k] = KEY_RELEASED;
               end
`ifdef AUTO_REPEAT_EN
               else if (rep_cnt_q[k] == (rep_phase_q[k] ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
                  pulse_d[k]     = 1'b1;
                  rep_phase_d[k] = 1'b1;
               end else begin
                  rep_cnt_d[k]   = rep_cnt_q[k] + REP_ONE;
                  rep_phase_d[k] = rep_phase_q[k];
               end
`endif
            end
            default: begin
               state_d[k] = KEY_RELEASED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            sync_q[i]  <= {SYNC_STAGES{KEY_IDLE}};
            state_q[i] <= KEY_RELEASED;
         end
         sync_q[4] <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
         deb_q      <= '0;
         pulse_q    <= '0;
         any_held_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            sync_q[i] <= sync_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
         end
         deb_q      <= deb_d;
         pulse_q    <= pulse_d;
         any_held_q <= any_held_d;
      end
   end

`ifdef AUTO_REPEAT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            rep_cnt_q[i] <= '0;
         end
         rep_phase_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            rep_cnt_q[i] <= rep_cnt_d[i];
         end
         rep_phase_q <= rep_phase_d;
      end
   end
`endif

   assign leftButton      = pulse_q[0];
   assign rightButton     = pulse_q[1];
   assign downButton      = pulse_q[2];
   assign upButton        = pulse_q[3];
   assign startGameSwitch = deb_q[4];
   assign anyKeyHeld      = any_held_q;

endmodule

// File: tb/tb_movement_button_conditioner.sv
// tb_movement_button_conditioner
//
// Self-checking bench for movement_button_conditioner. It runs with
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RAW_ACTIVE_LOW=1, REPEAT_DELAY=8 and
// REPEAT_PERIOD=3.
//
// The reference model describes each channel as "the input seen
// SYNC_STAGES edges late". It flips the accepted level once the last
// DEBOUNCE_CYCLES samples all disagree with that level. Pulses come from
// rising edges of the accepted level, plus hold-time arithmetic when
// AUTO_REPEAT_EN is defined.
//
// Packed output vector: {startGameSwitch, anyKeyHeld, up, down, right, left}.

module tb_movement_button_conditioner;

   localparam int SYNC   = 2;
   localparam int DEB    = 4;
   localparam int RDELAY = 8;
   localparam int RPER   = 3;

   logic       clk;
   logic       reset;
   logic [3:0] rawKeys;
   logic       rawSwitch;
   logic       leftButton;
   logic       rightButton;
   logic       upButton;
   logic       downButton;
   logic       startGameSwitch;
   logic       anyKeyHeld;
   logic [5:0] dut_out;

   movement_button_conditioner #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .RAW_ACTIVE_LOW  (1),
      .REPEAT_DELAY    (RDELAY),
      .REPEAT_PERIOD   (RPER)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .rawKeys         (rawKeys),
      .rawSwitch       (rawSwitch),
      .leftButton      (leftButton),
      .rightButton     (rightButton),
      .upButton        (upButton),
      .downButton      (downButton),
      .startGameSwitch (startGameSwitch),
      .anyKeyHeld      (anyKeyHeld)
   );

   assign dut_out = {startGameSwitch, anyKeyHeld, upButton, downButton, rightButton, leftButton};

   // 10-time-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   bit         pipe  [5][$];
   bit         win   [5][$];
   bit         mdeb  [5];
   int         held  [4];
   logic [5:0] mexp;

   function automatic void model_reset();
      for (int c = 0; c < 5; c++) begin
         pipe[c].delete();
         for (int j = 0; j < SYNC; j++) pipe[c].push_back(1'b0);
         win[c].delete();
         mdeb[c] = 1'b0;
      end
      for (int k = 0; k < 4; k++) held[k] = 0;
      mexp = '0;
   endfunction

   function automatic void model_edge(input logic [3:0] k, input logic s);
      bit [4:0] pressed;
      bit [3:0] pulse;
      bit       flip;
      bit       rose;
      bit       smp;
      pressed = {s, ~k};
      pulse   = '0;
      for (int c = 0; c < 5; c++) begin
         smp = pipe[c].pop_front();
         pipe[c].push_back(pressed[c]);
         win[c].push_back(smp);
         if (win[c].size() > DEB) void'(win[c].pop_front());
         flip = (win[c].size() == DEB);
         foreach (win[c][j]) if (win[c][j] == mdeb[c]) flip = 1'b0;
         rose = flip && !mdeb[c];
         if (flip) mdeb[c] = ~mdeb[c];
         if (c < 4) begin
            if (rose) begin
               pulse[c] = 1'b1;
               held[c]  = 0;
            end else if (mdeb[c]) begin
               held[c]++;
`ifdef AUTO_REPEAT_EN
               if (held[c] == RDELAY || (held[c] > RDELAY && (held[c] - RDELAY) % RPER == 0))
                  pulse[c] = 1'b1;
`endif
            end else begin
               held[c] = 0;
            end
         end
      end
      mexp = {mdeb[4], mdeb[0] | mdeb[1] | mdeb[2] | mdeb[3], pulse};
   endfunction

   task automatic check_output(input string name, input logic [5:0] got, input logic [5:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // Drive one cycle's inputs on the falling edge, advance the model on the
   // rising edge, and compare the DUT against the model 1 time unit later.
   task automatic apply_stimulus(input logic [3:0] k, input logic s, input logic r,
                                 input string name, output logic [5:0] got);
      @(negedge clk);
      rawKeys   = k;
      rawSwitch = s;
      reset     = r;
      @(posedge clk);
      if (!r) model_reset();
      else    model_edge(k, s);
      #1;
      got = dut_out;
      check_output(name, got, mexp);
   endtask

   typedef struct {
      logic [3:0] keys;
      logic       sw;
      logic       rst;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs [60];

   initial begin
      logic [5:0] got;
      logic [3:0] rkeys;
      logic       rsw;
      int         cnt_a;
      int         cnt_b;
      int         edge_a;
      int         edge_b;

      reset     = 1'b0;
      rawKeys   = 4'b1111;
      rawSwitch = 1'b0;
      model_reset();

      // Vector table. Rows 0-3 are in reset, rows 4-23 are idle, rows 24-43
      // hold left pressed, and rows 44-59 are idle again. The left pulse
      // lands on the 6th press edge (row 29). The release is accepted on
      // the 6th release edge (row 49).
      for (int r = 0; r < 60; r++) begin
         vecs[r].rst  = (r >= 4);
         vecs[r].keys = (r >= 24 && r < 44) ? 4'b1110 : 4'b1111;
         vecs[r].sw   = 1'b0;
         vecs[r].exp  = '0;
         if (r >= 29 && r <= 48) vecs[r].exp[4] = 1'b1;
         if (r == 29) vecs[r].exp[0] = 1'b1;
`ifdef AUTO_REPEAT_EN
         if (r == 37 || r == 40 || r == 43 || r == 46) vecs[r].exp[0] = 1'b1;
`endif
      end

      for (int r = 0; r < 60; r++) begin
         apply_stimulus(vecs[r].keys, vecs[r].sw, vecs[r].rst, $sformatf("model_tbl%0d", r), got);
         check_output($sformatf("table_row%0d", r), got, vecs[r].exp);
      end

      // Bounce on right: the key toggles every cycle, so it never stays
      // stable long enough to be accepted.
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         apply_stimulus((i < 10 && (i % 2 == 0)) ? 4'b1101 : 4'b1111, 1'b0, 1'b1,
                        $sformatf("model_bounce%0d", i), got);
         if (got[1]) cnt_a++;
         if (got[4]) cnt_b++;
      end
      check_output("bounce_right_pulses", 6'(cnt_a), 6'd0);
      check_output("bounce_any_held", 6'(cnt_b), 6'd0);

      // Simultaneous up + down press.
      edge_a = 0;
      edge_b = 0;
      cnt_a  = 0;
      for (int i = 1; i <= 12; i++) begin
         apply_stimulus(4'b0011, 1'b0, 1'b1, $sformatf("model_simul%0d", i), got);
         if (got[3] && edge_a == 0) edge_a = i;
         if (got[2] && edge_b == 0) edge_b = i;
         if (got[1] || got[0]) cnt_a++;
      end
      check_output("simul_up_edge", 6'(edge_a), 6'd6);
      check_output("simul_down_edge", 6'(edge_b), 6'd6);
      check_output("simul_left_right_quiet", 6'(cnt_a), 6'd0);
      for (int i = 0; i < 10; i++)
         apply_stimulus(4'b1111, 1'b0, 1'b1, $sformatf("model_simul_rel%0d", i), got);

      // Switch path with a 2-cycle dropout: high on edges 1-2, low on
      // edges 3-4, then high from edge 5 on. The window restarts, so the
      // switch is accepted on edge 10.
      edge_a = 0;
      cnt_a  = 0;
      for (int i = 1; i <= 14; i++) begin
         apply_stimulus(4'b1111, (i == 3 || i == 4) ? 1'b0 : 1'b1, 1'b1,
                        $sformatf("model_switch%0d", i), got);
         if (got[5] && edge_a == 0) edge_a = i;
         if (got[3:0] != 4'b0000) cnt_a++;
      end
      check_output("switch_rise_edge", 6'(edge_a), 6'd10);
      check_output("switch_no_key_pulse", 6'(cnt_a), 6'd0);
      for (int i = 0; i < 10; i++)
         apply_stimulus(4'b1111, 1'b0, 1'b1, $sformatf("model_switch_off%0d", i), got);

      // Reset in the middle of holding up.
      for (int i = 0; i < 10; i++)
         apply_stimulus(4'b0111, 1'b0, 1'b1, $sformatf("model_hold_up%0d", i), got);
      check_output("hold_before_reset", dut_out, 6'b010000);
      #2;
      reset = 1'b0;
      #1;
      check_output("async_reset_clear", dut_out, 6'b000000);
      model_reset();
      for (int i = 0; i < 2; i++)
         apply_stimulus(4'b0111, 1'b0, 1'b0, $sformatf("model_in_reset%0d", i), got);
      edge_a = 0;
      cnt_a  = 0;
      for (int i = 1; i <= 12; i++) begin
         apply_stimulus(4'b0111, 1'b0, 1'b1, $sformatf("model_post_reset%0d", i), got);
         if (got[3]) begin
            cnt_a++;
            if (edge_a == 0) edge_a = i;
         end
      end
      check_output("post_reset_up_count", 6'(cnt_a), 6'd1);
      check_output("post_reset_up_edge", 6'(edge_a), 6'd6);
      for (int i = 0; i < 10; i++)
         apply_stimulus(4'b1111, 1'b0, 1'b1, $sformatf("model_post_rel%0d", i), got);

      // Random sticky inputs. Occasional flips create both clean presses
      // and short bounces.
      rkeys = 4'b1111;
      rsw   = 1'b0;
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 4; k++)
            if ($urandom_range(11) == 0) rkeys[k] = ~rkeys[k];
         if ($urandom_range(15) == 0) rsw = ~rsw;
         apply_stimulus(rkeys, rsw, 1'b1, $sformatf("model_rand%0d", i), got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
